decoder_n_seq: RTL

- Parametrised registered SEL_W-to-2^SEL_W decoder that generalises the team's fixed 3-to-8 registered decoder.
- Three run-time modes:
  - DECODE: plain one-hot decode.
  - LATCH: sticky accumulate of decoded bits.
  - SCAN: self-sequencing walking one with programmable dwell.
- Sits in front of select/enable fan-out (chip selects, LED/column scan, channel strobes). All outputs are registered.

---
 rtl/decoder_pkg.sv | 25 ++
 rtl/scan_step_counter.sv | 62 ++++++
 rtl/decoder_n_seq.sv | 123 ++++++++++++
 3 files changed

// File: rtl/decoder_pkg.sv
// Shared encodings, FSM states and one-hot helper for the registered
// select decoder family.
package decoder_pkg;

  localparam logic [1:0] MODE_DEC = 2'b00;
  localparam logic [1:0] MODE_LAT = 2'b01;
  localparam logic [1:0] MODE_SCN = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    DEC,
    LAT,
    SCN
  } state_e;

  // Widest decode supported; callers size-cast the result down to their OUT_W.
  localparam int MAX_SEL_W = 6;
  localparam int MAX_OUT_W = 2 ** MAX_SEL_W;

  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
    return {{(MAX_OUT_W - 1) {1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/scan_step_counter.sv
// Dwell counter, walking index and wrap pulse for the SCAN mode.
// Held at zero whenever the scan is not running, so entry always starts at 0.
module scan_step_counter #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               active_i,
  input  logic               en_i,
  input  logic               clr_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic [SEL_W-1:0]   idx_o,
  output logic [SEL_W-1:0]   idx_d_o,
  output logic               wrap_o
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic               wrap_q, wrap_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    wrap_d = 1'b0;
    if (!active_i) begin
      cnt_d = '0;
      idx_d = '0;
    end else if (en_i) begin
      if (clr_i) begin
        cnt_d = '0;
        idx_d = '0;
      end else if (cnt_q == dwell_i) begin
        cnt_d  = '0;
        idx_d  = idx_q + SEL_W'(1);
        wrap_d = (idx_q == {SEL_W{1'b1}});
      end else begin
        cnt_d = cnt_q + DWELL_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      wrap_q <= wrap_d;
    end
  end

  assign idx_o   = idx_q;
  assign idx_d_o = idx_d;
  assign wrap_o  = wrap_q;

endmodule

// File: rtl/decoder_n_seq.sv
// Registered SEL_W-to-2**SEL_W decoder with DECODE, LATCH and SCAN modes;
// every mode change passes through one IDLE cycle with out cleared.
module decoder_n_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic                  en,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  sel_valid,
  input  logic                  clr,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [2**SEL_W-1:0]   out,
  output logic                  out_valid,
  output logic [SEL_W-1:0]      scan_idx,
  output logic                  wrap
);

  localparam int OUT_W = 2 ** SEL_W;

  state_e             state_q;
  logic [OUT_W-1:0]   out_q;
  logic               out_valid_q;
  logic [SEL_W-1:0]   scan_idx_d;
  logic [OUT_W-1:0]   sel_onehot;
  logic [OUT_W-1:0]   scan_onehot;
  logic [OUT_W-1:0]   lat_d;
  logic               scan_active;

  assign scan_active = (state_q == SCN) && (mode == MODE_SCN);

  scan_step_counter #(
    .SEL_W   (SEL_W),
    .DWELL_W (DWELL_W)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .active_i (scan_active),
    .en_i     (en),
    .clr_i    (clr),
    .dwell_i  (dwell),
    .idx_o    (scan_idx),
    .idx_d_o  (scan_idx_d),
    .wrap_o   (wrap)
  );

  always_comb begin
    sel_onehot  = OUT_W'(onehot(MAX_SEL_W'(sel)));
    scan_onehot = OUT_W'(onehot(MAX_SEL_W'(scan_idx_d)));
    // Clear applies before the set so clr+sel_valid leaves only the new bit.
    lat_d = (clr ? '0 : out_q) | (sel_valid ? sel_onehot : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          out_q       <= '0;
          out_valid_q <= 1'b0;
          case (mode)
            MODE_DEC: state_q <= DEC;
            MODE_LAT: state_q <= LAT;
            MODE_SCN: begin
              state_q     <= SCN;
              out_q       <= OUT_W'(1);
              out_valid_q <= 1'b1;
            end
            default:  state_q <= IDLE;
          endcase
        end
        DEC: begin
          if (mode != MODE_DEC) begin
            state_q     <= IDLE;
            out_q       <= '0;
            out_valid_q <= 1'b0;
          end else if (en && sel_valid) begin
            out_q       <= sel_onehot;
            out_valid_q <= 1'b1;
          end else begin
            out_valid_q <= 1'b0;
          end
        end
        LAT: begin
          if (mode != MODE_LAT) begin
            state_q     <= IDLE;
            out_q       <= '0;
            out_valid_q <= 1'b0;
          end else if (en) begin
            out_q       <= lat_d;
            out_valid_q <= (lat_d != '0);
          end
        end
        SCN: begin
          if (mode != MODE_SCN) begin
            state_q     <= IDLE;
            out_q       <= '0;
            out_valid_q <= 1'b0;
          end else begin
            out_q       <= scan_onehot;
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_q       <= '0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule
